carry_lookahead_adder: RTL and testbench
========================================

// Module: carry_lookahead_adder
//
// PURPOSE
//   Two's-complement adder, WIDTH bits wide, built on a hierarchical carry-lookahead
//   structure. Sum, carry-out and signed-overflow outputs are registered.
//   Serves as the fast-add building block of the adder family. Feeds datapath
//   stages that need a+b+cin with signed overflow detection.
//
// PARAMETERS
//   WIDTH  32  operand/sum width in bits; must be a multiple of 4 (4-bit CLA groups)
//
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   a         in   WIDTH  operand A, two's complement
//   b         in   WIDTH  operand B, two's complement
//   cin       in   1      carry-in (LSB)
//   sum       out  WIDTH  registered (a + b + cin) mod 2^WIDTH
//   cout      out  1      registered carry out of MSB (unsigned carry)
//   overflow  out  1      registered signed overflow flag
//
// BEHAVIOUR
//   - Reset: rst_n low forces sum=0, cout=0, overflow=0 immediately.
//     This is independent of clk. Outputs hold these values while rst_n is low.
//   - Latency: 1 cycle. Operands and cin are sampled at each rising clk edge.
//     The result is visible after that edge. Throughput is one add per cycle.
//     No handshake and no stall.
//   - First rising edge after rst_n deasserts loads the result of the operands present at that edge.
//   - Reset mid-stream discards any pending result. There is no state beyond the output registers.
//   - Core (combinational), per bit: p[i]=a[i]^b[i], g[i]=a[i]&b[i].
//   - 4-bit groups:
//     - carries computed by lookahead equations from p/g and the group carry-in;
//     - group signals GP = &p, GG = g3|p3g2|p3p2g1|p3p2p1g0.
//   - Group carries come from a second lookahead level over GP/GG of up to 4 groups.
//     A further level is added for >16 groups' worth, i.e. WIDTH>64.
//     For WIDTH=32, 8 groups form two super-groups combined at a third level.
//   - No ripple chain across group boundaries.
//   - sum[i] = p[i] ^ c[i], with c[0] = cin.
//   - cout = c[WIDTH] (carry out of the MSB).
//   - overflow = c[WIDTH] ^ c[WIDTH-1]. Equivalently: operands have equal sign
//     and the sum sign differs.
//   - Wrap-around: the sum is always the low WIDTH bits. Overflow only flags and
//     never saturates.
//   - All inputs treated as 2-state. X on inputs may propagate to outputs; no X-masking.
//
// TESTING
//   Checks are one cycle after applying operands; WIDTH=32, cin=0 unless noted.
//   1. a=0x7FFFFFFF, b=0x00000001
//      -> sum=0x80000000, cout=0, overflow=1.
//   2. a=0x80000000, b=0xFFFFFFFF
//      -> sum=0x7FFFFFFF, cout=1, overflow=1.
//   3. Mixed signs and same signs, one per cycle back-to-back
//      (each result exactly one cycle after its operands):
//      - 100 + -50 -> 50, cout=1, ovf=0
//      - 200 + 150 -> 350, cout=0, ovf=0
//      - -100 + -200 -> -300 (0xFFFFFED4), cout=1, ovf=0
//   4. Zero results:
//      - -50 + 50 -> 0, cout=1, ovf=0
//      - a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0 (full carry propagate through all groups)
//   5. Carry-chain sweep: a=0x0000FFFF, b=0x00000001 -> 0x00010000, ovf=0.
//      Then 1000 random (a,b,cin) vectors vs a behavioural a+b+cin model on all three outputs.
//   6. Reset: drive a=5, b=7 and clock once -> sum=12.
//      Pull rst_n low between edges -> outputs 0 immediately, without a clock edge.
//      Release and clock -> sum=12 again.

Source files
------------

// File: rtl/carry_lookahead_adder.sv
// Registered two's-complement adder built on a multi-level 4-way carry-lookahead tree.
// Produces sum = a + b + cin (mod 2^WIDTH), the unsigned carry-out and the signed overflow flag.
module carry_lookahead_adder #(
    parameter int WIDTH = 32  // must be a multiple of 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // No valid/ready handshake: every rising edge is one transaction, and the
    // result of the operands sampled at an edge is on the outputs after that edge.

    // Each tree level reduces its node count by four until a single root remains.
    function automatic int level_count(input int w);
        int n;
        int l;
        n = w;
        l = 0;
        while (n > 1) begin
            n = (n + 3) / 4;
            l = l + 1;
        end
        return l;
    endfunction

    localparam int NLVL = level_count(WIDTH);
    // Slot count per level; spare slots hold a neutral node (propagate=1, generate=0).
    localparam int AW   = WIDTH + 4;
    localparam int NSLOT = AW / 4;

    // Group generate/propagate of four children, written as a flat sum of products.
    function automatic logic [1:0] group_pg(input logic [3:0] p4, input logic [3:0] g4);
        logic gp;
        logic gg;
        gp = &p4;
        gg = g4[3]
           | (p4[3] & g4[2])
           | (p4[3] & p4[2] & g4[1])
           | (p4[3] & p4[2] & p4[1] & g4[0]);
        return {gp, gg};
    endfunction

    // Carries into the four children from the carry entering their parent.
    function automatic logic [3:0] lookahead(input logic [3:0] p4, input logic [3:0] g4,
                                             input logic ci);
        logic c1;
        logic c2;
        logic c3;
        c1 = g4[0] | (p4[0] & ci);
        c2 = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ci);
        c3 = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
           | (p4[2] & p4[1] & p4[0] & ci);
        return {c3, c2, c1, ci};
    endfunction

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [AW-1:0]    gp_lv [0:NLVL];
    logic [AW-1:0]    gg_lv [0:NLVL];
    logic [AW-1:0]    c_lv  [0:NLVL];
    logic [WIDTH-1:0] carry;
    logic             carry_msb_out;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             overflow_next;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        logic [1:0] pg;
        for (int l = 0; l <= NLVL; l++) begin
            gp_lv[l] = '1;
            gg_lv[l] = '0;
            c_lv[l]  = '0;
        end
        gp_lv[0][WIDTH-1:0] = p;
        gg_lv[0][WIDTH-1:0] = g;

        // Upward pass: group propagate/generate at every level of the tree.
        for (int l = 1; l <= NLVL; l++) begin
            for (int j = 0; j < NSLOT; j++) begin
                pg = group_pg(gp_lv[l-1][4*j +: 4], gg_lv[l-1][4*j +: 4]);
                gp_lv[l][j] = pg[1];
                gg_lv[l][j] = pg[0];
            end
        end

        // Downward pass: each node hands lookahead carries to its children.
        c_lv[NLVL][0] = cin;
        for (int l = NLVL; l >= 1; l--) begin
            for (int j = 0; j < NSLOT; j++) begin
                c_lv[l-1][4*j +: 4] = lookahead(gp_lv[l-1][4*j +: 4],
                                                gg_lv[l-1][4*j +: 4],
                                                c_lv[l][j]);
            end
        end
    end

    assign carry         = c_lv[0][WIDTH-1:0];
    assign carry_msb_out = gg_lv[NLVL][0] | (gp_lv[NLVL][0] & cin);

    assign sum_next      = p ^ carry;
    assign cout_next     = carry_msb_out;
    assign overflow_next = carry_msb_out ^ carry[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sum      <= sum_next;
            cout     <= cout_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Bench for carry_lookahead_adder: directed vector table, random vectors against an
// a+b+cin model, and an asynchronous reset sequence, all through an expected-result queue.
module tb_carry_lookahead_adder;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    logic [W+1:0] exp_q[$];
    int           checks;
    int           errors;

    carry_lookahead_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got sum=%h cout=%0b ovf=%0b, expected sum=%h cout=%0b ovf=%0b",
                     name, act[W+1:2], act[1], act[0], exp[W+1:2], exp[1], exp[0]);
        end
    endtask

    // Driver: apply operands at a falling edge, queue the expectation, then compare
    // the DUT output one rising edge later.
    task automatic step(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vcin, input logic [W+1:0] exp);
        logic [W+1:0] e;
        a   = va;
        b   = vb;
        cin = vcin;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, {sum, cout, overflow}, e);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                          input logic vcin);
        logic [W:0]   full;
        logic         ovf;
        full = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vcin};
        ovf  = (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1]);
        return {full[W-1:0], full[W], ovf};
    endfunction

    vec_t vecs [0:9];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;

        vecs[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[2] = '{32'd100,       32'hFFFF_FFCE, 1'b0, 32'd50,        1'b1, 1'b0};
        vecs[3] = '{32'd200,       32'd150,       1'b0, 32'd350,       1'b0, 1'b0};
        vecs[4] = '{32'hFFFF_FF9C, 32'hFFFF_FF38, 1'b0, 32'hFFFF_FED4, 1'b1, 1'b0};
        vecs[5] = '{32'hFFFF_FFCE, 32'd50,        1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};

        @(negedge clk);
        @(negedge clk);
        check("reset_state", {sum, cout, overflow}, '0);
        rst_n = 1'b1;

        // Directed table, applied back to back
        for (int i = 0; i < 10; i++) begin
            step($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                 {vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf});
        end

        // Random vectors against the behavioural model
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            step($sformatf("rand%0d", i), ra, rb, rc, model(ra, rb, rc));
        end

        // Asynchronous reset between edges, then recovery
        step("pre_reset", 32'd5, 32'd7, 1'b0, {32'd12, 1'b0, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {sum, cout, overflow}, '0);
        @(negedge clk);
        check("reset_hold", {sum, cout, overflow}, '0);
        rst_n = 1'b1;
        step("post_reset", 32'd5, 32'd7, 1'b0, {32'd12, 1'b0, 1'b0});

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
